// File: rtl/fpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Package   : fpu_pkg
// Purpose   : Constants shared by the FPU issue controller and FPU datapath.
//             Holds the fpuOp encodings, the per-op latencies and the issue
//             FSM state codes.
// Revision  : 1.0 - initial release
// ---------------------------------------------------------------------------
package fpu_pkg;

  // fpuOp encodings. Codes 10..15 are unassigned and are treated as illegal.
  typedef enum logic [3:0] {
    FPU_ADD    = 4'd0,
    FPU_SUB    = 4'd1,
    FPU_MUL    = 4'd2,
    FPU_DIV    = 4'd3,
    FPU_SGNJ   = 4'd4,
    FPU_MINMAX = 4'd5,
    FPU_SQRT   = 4'd6,
    FPU_CMP    = 4'd7,
    FPU_CVT_W  = 4'd8,
    FPU_CVT_S  = 4'd9
  } fpu_op_e;

  // Latency L per op: the result is sampled at the end of the BUSY cycle
  // in which the counter equals L.
  localparam int LAT_ADD    = 7;
  localparam int LAT_SUB    = 7;
  localparam int LAT_MUL    = 5;
  localparam int LAT_DIV    = 6;
  localparam int LAT_SGNJ   = 0;
  localparam int LAT_MINMAX = 1;
  localparam int LAT_SQRT   = 16;
  localparam int LAT_CMP    = 1;
  localparam int LAT_CVT_W  = 6;
  localparam int LAT_CVT_S  = 6;

  // Issue FSM state codes.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/fpu_lat_lut.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module    : fpu_lat_lut
// Purpose   : Combinational decode of an fpuOp code into its latency and an
//             illegal-op flag.
// Ports     : i_op      [3:0]       fpuOp code
//             o_lat     [CNT_W-1:0] latency L for the op (0 when illegal)
//             o_illegal             op code is outside 0..9
// Revision  : 1.0 - initial release
// ---------------------------------------------------------------------------
module fpu_lat_lut
  import fpu_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic [3:0]       i_op,
  output logic [CNT_W-1:0] o_lat,
  output logic             o_illegal
);

  always_comb begin
    o_lat     = '0;
    o_illegal = 1'b0;
    case (i_op)
      FPU_ADD:    o_lat = CNT_W'(LAT_ADD);
      FPU_SUB:    o_lat = CNT_W'(LAT_SUB);
      FPU_MUL:    o_lat = CNT_W'(LAT_MUL);
      FPU_DIV:    o_lat = CNT_W'(LAT_DIV);
      FPU_SGNJ:   o_lat = CNT_W'(LAT_SGNJ);
      FPU_MINMAX: o_lat = CNT_W'(LAT_MINMAX);
      FPU_SQRT:   o_lat = CNT_W'(LAT_SQRT);
      FPU_CMP:    o_lat = CNT_W'(LAT_CMP);
      FPU_CVT_W:  o_lat = CNT_W'(LAT_CVT_W);
      FPU_CVT_S:  o_lat = CNT_W'(LAT_CVT_S);
      default:    o_illegal = 1'b1;
    endcase
  end

endmodule : fpu_lat_lut
`default_nettype wire

// File: rtl/fpu_issue_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module    : fpu_issue_ctrl
// Purpose   : Sequences the multi-cycle FPU for the EX stage. Accepts one FP
//             op at a time, holds its op/func3/rs1[0] fields for the FPU,
//             counts the op latency, captures the FPU result and returns it
//             with its rd tag as a one-cycle writeback pulse. Stalls EX while
//             an op is in flight.
// Ports     : clock, clear (async, active-low)
//             issue_valid/op/func3/rs1_0/rd  - op presented by EX
//             flush                          - synchronous pipeline flush
//             fpu_result                     - FPU result bus
//             issue_ready, stall, opnd_load  - issue handshake
//             fpu_op_q/func3_q/rs1_0_q       - held fields driven to the FPU
//             busy                           - FSM not idle
//             wb_valid/rd/data, illegal_op   - writeback pulse and payload
// Revision  : 1.0 - initial release
// ---------------------------------------------------------------------------
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             issue_valid,
  input  logic [3:0]       issue_op,
  input  logic [2:0]       issue_func3,
  input  logic             issue_rs1_0,
  input  logic [RD_W-1:0]  issue_rd,
  input  logic             flush,
  input  logic [WIDTH-1:0] fpu_result,
  output logic             issue_ready,
  output logic             stall,
  output logic             opnd_load,
  output logic [3:0]       fpu_op_q,
  output logic [2:0]       fpu_func3_q,
  output logic             fpu_rs1_0_q,
  output logic             busy,
  output logic             wb_valid,
  output logic [RD_W-1:0]  wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             illegal_op
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_lat;
  logic             r_ill;
  logic [RD_W-1:0]  r_rd;
  logic [3:0]       r_op;
  logic [2:0]       r_func3;
  logic             r_rs1_0;
  logic [RD_W-1:0]  r_wb_rd;
  logic [WIDTH-1:0] r_wb_data;
  logic             r_wb_ill;

  logic [CNT_W-1:0] w_lat;
  logic             w_illegal;
  logic             w_ready;
  logic             w_accept;

  // Latency is decoded from the live op only at accept and then held, so the
  // running count never depends on whatever EX presents later.
  fpu_lat_lut #(
    .CNT_W (CNT_W)
  ) u_lat_lut (
    .i_op      (issue_op),
    .o_lat     (w_lat),
    .o_illegal (w_illegal)
  );

  // DONE is ready so a new op can issue under the writeback pulse.
  assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_accept = issue_valid && w_ready && !flush;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_lat     <= '0;
      r_ill     <= 1'b0;
      r_rd      <= '0;
      r_op      <= '0;
      r_func3   <= '0;
      r_rs1_0   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
      r_wb_ill  <= 1'b0;
    end else begin
      // Op fields stay put until the next accept; returning to IDLE does not
      // clear them.
      if (w_accept) begin
        r_op    <= issue_op;
        r_func3 <= issue_func3;
        r_rs1_0 <= issue_rs1_0;
        r_rd    <= issue_rd;
        r_lat   <= w_lat;
        r_ill   <= w_illegal;
        r_cnt   <= '0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Flush drops the in-flight op, even on its final count cycle.
          if (flush) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == r_lat) begin
            r_wb_rd   <= r_rd;
            r_wb_data <= r_ill ? '0 : fpu_result;
            r_wb_ill  <= r_ill;
            r_state   <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_DONE: begin
          r_state <= w_accept ? ST_BUSY : ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign issue_ready = w_ready;
  assign stall       = issue_valid && !w_ready;
  assign opnd_load   = w_accept;
  assign busy        = (r_state != ST_IDLE);
  assign wb_valid    = (r_state == ST_DONE);
  assign fpu_op_q    = r_op;
  assign fpu_func3_q = r_func3;
  assign fpu_rs1_0_q = r_rs1_0;
  assign wb_rd       = r_wb_rd;
  assign wb_data     = r_wb_data;
  assign illegal_op  = r_wb_ill;

endmodule : fpu_issue_ctrl
`default_nettype wire

// File: tb/tb_fpu_issue_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module    : tb_fpu_issue_ctrl
// Purpose   : Self-checking bench for fpu_issue_ctrl. A timing-level model
//             (op in flight, writeback due cycle) predicts every output each
//             cycle; directed tables and sequences cover the corner cases.
// Revision  : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_fpu_issue_ctrl;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        issue_valid = 1'b0;
  logic [3:0]  issue_op = '0;
  logic [2:0]  issue_func3 = '0;
  logic        issue_rs1_0 = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        flush = 1'b0;
  logic [31:0] fpu_result = '0;
  logic        issue_ready, stall, opnd_load, fpu_rs1_0_q, busy, wb_valid, illegal_op;
  logic [3:0]  fpu_op_q;
  logic [2:0]  fpu_func3_q;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  fpu_issue_ctrl #(.WIDTH(32), .RD_W(5), .CNT_W(5)) dut (
    .clock(clock), .clear(clear), .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_func3(issue_func3), .issue_rs1_0(issue_rs1_0), .issue_rd(issue_rd),
    .flush(flush), .fpu_result(fpu_result), .issue_ready(issue_ready), .stall(stall),
    .opnd_load(opnd_load), .fpu_op_q(fpu_op_q), .fpu_func3_q(fpu_func3_q),
    .fpu_rs1_0_q(fpu_rs1_0_q), .busy(busy), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .illegal_op(illegal_op)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  int          k;            // cycle index
  bit          m_inflight;   // an op is between accept and its writeback cycle
  int          m_due;        // cycle in which wb_valid is expected
  bit          m_ill;
  logic [4:0]  m_rd;
  logic [3:0]  m_opq;
  logic [2:0]  m_f3q;
  logic        m_rsq;
  logic [4:0]  m_wbrd;
  logic [31:0] m_wbdata;
  logic        m_wbill;

  function automatic int lat_of(input logic [3:0] op);
    case (op)
      4'd0, 4'd1:       return 7;
      4'd2:             return 5;
      4'd3, 4'd8, 4'd9: return 6;
      4'd4:             return 0;
      4'd5, 4'd7:       return 1;
      4'd6:             return 16;
      default:          return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_inflight = 0; m_due = 0; m_ill = 0; m_rd = '0;
    m_opq = '0; m_f3q = '0; m_rsq = 1'b0;
    m_wbrd = '0; m_wbdata = '0; m_wbill = 1'b0;
  endtask

  task automatic model_update();
    bit done, rdy, acc;
    done = m_inflight && (k == m_due);
    rdy  = !m_inflight || done;
    acc  = issue_valid && rdy && !flush;
    if (m_inflight && (k == m_due - 1) && !flush) begin
      m_wbrd   = m_rd;
      m_wbdata = m_ill ? 32'h0 : fpu_result;
      m_wbill  = m_ill;
    end
    if (m_inflight && (done || (flush && k < m_due))) m_inflight = 0;
    if (acc) begin
      m_inflight = 1;
      m_due      = k + lat_of(issue_op) + 2;
      m_ill      = (issue_op > 4'd9);
      m_rd       = issue_rd;
      m_opq      = issue_op;
      m_f3q      = issue_func3;
      m_rsq      = issue_rs1_0;
    end
    k++;
  endtask

  task automatic check_model();
    bit done, rdy, acc, stl;
    logic [50:0] act, exp;
    done = m_inflight && (k == m_due);
    rdy  = !m_inflight || done;
    acc  = issue_valid && rdy && !flush;
    stl  = issue_valid && !rdy;
    exp = {rdy, stl, acc, m_inflight, done, m_wbill, m_opq, m_f3q, m_rsq, m_wbrd, m_wbdata};
    act = {issue_ready, stall, opnd_load, busy, wb_valid, illegal_op, fpu_op_q,
           fpu_func3_q, fpu_rs1_0_q, wb_rd, wb_data};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL model cyc=%0d got=%h want=%h", k, act, exp);
    end
  endtask

  task automatic expect_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Called at posedge+1: applies inputs, then waits to mid-cycle.
  task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] f3,
                       input logic r0, input logic [4:0] rd, input logic fl,
                       input logic [31:0] res);
    issue_valid = v; issue_op = op; issue_func3 = f3; issue_rs1_0 = r0;
    issue_rd = rd; flush = fl; fpu_result = res;
    #4;
  endtask

  task automatic tick();
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 4'd0, 3'd0, 1'b0, 5'd0, 1'b0, 32'h0);
      check_model();
      tick();
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        fl;
    logic [31:0] res;
    logic        e_ready, e_load, e_busy, e_wbv;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [3:0] op, input logic [4:0] rd,
                              input logic [31:0] res, input logic rdy, input logic ld,
                              input logic bsy, input logic wbv, input logic [4:0] erd,
                              input logic [31:0] edata);
    vec_t t;
    t.v = v; t.op = op; t.rd = rd; t.fl = 1'b0; t.res = res;
    t.e_ready = rdy; t.e_load = ld; t.e_busy = bsy; t.e_wbv = wbv;
    t.e_rd = erd; t.e_data = edata;
    return t;
  endfunction

  initial begin
    // MUL rd=3: accept, six stall cycles, writeback at T0+7.
    tbl.push_back(mk(1, 4'd2, 5'd3, 32'h0, 1, 1, 0, 0, 5'd0, 32'h0));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 4'd2, 5'd3, 32'h40C00000, 0, 0, 1, 0, 5'd0, 32'h0));
    tbl.push_back(mk(0, 4'd0, 5'd0, 32'h40C00000, 1, 0, 1, 1, 5'd3, 32'h40C00000));
    tbl.push_back(mk(0, 4'd0, 5'd0, 32'h0, 1, 0, 0, 0, 5'd0, 32'h0));
    // SGNJ rd=5 then ADD rd=6 issued under the SGNJ writeback.
    tbl.push_back(mk(1, 4'd4, 5'd5, 32'h0, 1, 1, 0, 0, 5'd0, 32'h0));
    tbl.push_back(mk(1, 4'd0, 5'd6, 32'h11111111, 0, 0, 1, 0, 5'd0, 32'h0));
    tbl.push_back(mk(1, 4'd0, 5'd6, 32'h11111111, 1, 1, 1, 1, 5'd5, 32'h11111111));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 4'd0, 5'd0, 32'h22222222, 0, 0, 1, 0, 5'd0, 32'h0));
    tbl.push_back(mk(0, 4'd0, 5'd0, 32'h22222222, 1, 0, 1, 1, 5'd6, 32'h22222222));
    tbl.push_back(mk(0, 4'd0, 5'd0, 32'h0, 1, 0, 0, 0, 5'd0, 32'h0));

    // ---------------- reset ----------------
    model_reset();
    k = 0;
    @(posedge clock);
    @(posedge clock);
    #1;
    clear = 1'b1;

    drive(1'b0, 4'd0, 3'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    check_model();
    expect_val("reset_state",
               {issue_ready, busy, wb_valid, illegal_op, fpu_op_q, wb_rd, wb_data},
               {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 32'h0});
    tick();

    // ---------------- table ----------------
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].op, 3'd2, 1'b0, tbl[i].rd, tbl[i].fl, tbl[i].res);
      check_model();
      expect_val($sformatf("tbl%0d_hs", i), {issue_ready, opnd_load, busy, wb_valid, stall},
                 {tbl[i].e_ready, tbl[i].e_load, tbl[i].e_busy, tbl[i].e_wbv,
                  tbl[i].v & ~tbl[i].e_ready});
      if (tbl[i].e_wbv)
        expect_val($sformatf("tbl%0d_wb", i), {wb_rd, wb_data}, {tbl[i].e_rd, tbl[i].e_data});
      tick();
    end

    // ---------------- SQRT flushed at cnt=8 ----------------
    drive(1'b1, 4'd6, 3'd7, 1'b1, 5'd9, 1'b0, 32'hAAAA5555);
    check_model();
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'd0, 3'd0, 1'b0, 5'd0, 1'b0, 32'hAAAA5555);
      check_model();
      tick();
    end
    drive(1'b0, 4'd0, 3'd0, 1'b0, 5'd0, 1'b1, 32'hAAAA5555);
    check_model();
    tick();
    drive(1'b0, 4'd0, 3'd0, 1'b0, 5'd0, 1'b0, 32'hAAAA5555);
    check_model();
    expect_val("flush_to_idle", {busy, issue_ready, wb_valid}, 3'b010);
    tick();
    idle_cycles(10);
    drive(1'b1, 4'd5, 3'd1, 1'b0, 5'd12, 1'b0, 32'h0);
    check_model();
    expect_val("post_flush_accept", opnd_load, 1'b1);
    tick();
    idle_cycles(4);

    // ---------------- DIV with async clear at cnt=3 ----------------
    drive(1'b1, 4'd3, 3'd5, 1'b1, 5'd7, 1'b0, 32'h12345678);
    check_model();
    tick();
    idle_cycles(3);
    drive(1'b0, 4'd0, 3'd0, 1'b0, 5'd0, 1'b0, 32'h12345678);
    check_model();
    #1 clear = 1'b0;
    #1;
    expect_val("async_clear",
               {issue_ready, stall, busy, wb_valid, illegal_op, fpu_op_q, fpu_func3_q,
                fpu_rs1_0_q, wb_rd, wb_data},
               {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 5'd0, 32'h0});
    model_reset();
    @(posedge clock);
    #1;
    expect_val("clear_held", {busy, fpu_op_q}, {1'b0, 4'd0});
    clear = 1'b1;
    drive(1'b0, 4'd0, 3'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    check_model();
    expect_val("after_clear_ready", {issue_ready, busy}, 2'b10);
    tick();

    // ---------------- illegal op and flush-in-IDLE ----------------
    drive(1'b1, 4'd12, 3'd3, 1'b0, 5'd11, 1'b0, 32'hDEADBEEF);
    check_model();
    tick();
    drive(1'b0, 4'd0, 3'd0, 1'b0, 5'd0, 1'b0, 32'hDEADBEEF);
    check_model();
    tick();
    drive(1'b0, 4'd0, 3'd0, 1'b0, 5'd0, 1'b0, 32'hDEADBEEF);
    check_model();
    expect_val("illegal_wb", {wb_valid, illegal_op, wb_rd, wb_data}, {1'b1, 1'b1, 5'd11, 32'h0});
    tick();
    drive(1'b1, 4'd0, 3'd0, 1'b0, 5'd1, 1'b1, 32'h0);
    check_model();
    expect_val("flush_blocks_accept", {opnd_load, issue_ready}, 2'b01);
    tick();
    drive(1'b0, 4'd0, 3'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    check_model();
    expect_val("flush_idle_stays", busy, 1'b0);
    tick();

    // ---------------- randomized run against the model ----------------
    for (int i = 0; i < 600; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      drive($urandom_range(0, 2) != 0, op, 3'($urandom), 1'($urandom), 5'($urandom),
            $urandom_range(0, 11) == 0, $urandom);
      check_model();
      tick();
    end
    idle_cycles(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_fpu_issue_ctrl
`default_nettype wire
